// File: rtl/bp_me_wormhole_link_arbiter.sv
// rtl/bp_me_wormhole_link_arbiter.sv - packet-granular round-robin arbiter onto one wormhole link
module bp_me_wormhole_link_arbiter #(
    parameter int num_req_p    = 2,
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 4,
    parameter int len_width_p  = 4,
    parameter int hdr_len_p    = 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p*flit_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_and_o,
    output logic [flit_width_p-1:0]           link_data_o,
    output logic                              link_v_o,
    input  logic                              link_ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              is_hdr_o,
    output logic                              last_o
);

    localparam int ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w = len_width_p + 1;

    typedef enum logic {e_arb, e_lock} state_e;

    state_e             state_r, state_n;
    logic [ptr_w-1:0]   rr_ptr_r, rr_ptr_n;
    logic [ptr_w-1:0]   grant_r, grant_n;
    logic [cnt_w-1:0]   cnt_r, cnt_n;
    logic [cnt_w-1:0]   idx_r, idx_n;

    logic [ptr_w-1:0]        arb_g;
    logic                    any_v;
    logic [ptr_w-1:0]        sel;
    logic [flit_width_p-1:0] sel_flit;
    logic [cnt_w-1:0]        len_ext;
    logic                    hs;

    function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
        if (int'(p) == num_req_p - 1) return '0;
        return p + 1'b1;
    endfunction

    // Cyclic priority search: first valid requester at or after rr_ptr_r
    always_comb begin
        int cand;
        arb_g = '0;
        any_v = 1'b0;
        cand  = 0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_r) + i;
            if (cand >= num_req_p) cand = cand - num_req_p;
            if (req_v_i[cand]) begin
                arb_g = ptr_w'(cand);
                any_v = 1'b1;
            end
        end
    end

    assign sel      = (state_r == e_lock) ? grant_r : arb_g;
    assign sel_flit = req_data_i[int'(sel)*flit_width_p +: flit_width_p];
    assign len_ext  = {1'b0, sel_flit[cord_width_p +: len_width_p]};

    // Link-side outputs; everything is forced quiet while reset is held
    always_comb begin
        link_v_o    = 1'b0;
        link_data_o = '0;
        grant_o     = '0;
        is_hdr_o    = 1'b0;
        last_o      = 1'b0;
        if (reset_n_i) begin
            if (state_r == e_lock) begin
                link_v_o    = req_v_i[grant_r];
                link_data_o = sel_flit;
                grant_o     = {{(num_req_p-1){1'b0}}, 1'b1} << grant_r;
                is_hdr_o    = int'(idx_r) < hdr_len_p;
                last_o      = (cnt_r == cnt_w'(1));
            end else if (any_v) begin
                link_v_o    = 1'b1;
                link_data_o = sel_flit;
                grant_o     = {{(num_req_p-1){1'b0}}, 1'b1} << arb_g;
                is_hdr_o    = 1'b1;
                last_o      = (len_ext == '0);
            end
        end
    end

    assign req_ready_and_o = grant_o & {num_req_p{link_ready_and_i & reset_n_i}};
    assign hs              = link_v_o & link_ready_and_i;

    // Next-state: lock on first presented flit, release after last flit is accepted
    always_comb begin
        state_n  = state_r;
        rr_ptr_n = rr_ptr_r;
        grant_n  = grant_r;
        cnt_n    = cnt_r;
        idx_n    = idx_r;
        case (state_r)
            e_arb: begin
                if (any_v) begin
                    if (hs) begin
                        if (len_ext == '0) begin
                            rr_ptr_n = wrap_inc(arb_g);
                        end else begin
                            state_n = e_lock;
                            grant_n = arb_g;
                            cnt_n   = len_ext;
                            idx_n   = cnt_w'(1);
                        end
                    end else begin
                        // Freeze the choice so a later higher-priority arrival cannot swap the flit
                        state_n = e_lock;
                        grant_n = arb_g;
                        cnt_n   = len_ext + cnt_w'(1);
                        idx_n   = '0;
                    end
                end
            end
            e_lock: begin
                if (hs) begin
                    cnt_n = cnt_r - cnt_w'(1);
                    idx_n = (idx_r == '1) ? idx_r : idx_r + cnt_w'(1);
                    if (cnt_r == cnt_w'(1)) begin
                        state_n  = e_arb;
                        rr_ptr_n = wrap_inc(grant_r);
                        idx_n    = '0;
                    end
                end
            end
            default: state_n = e_arb;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_arb;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            cnt_r    <= '0;
            idx_r    <= '0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            grant_r  <= grant_n;
            cnt_r    <= cnt_n;
            idx_r    <= idx_n;
        end
    end

endmodule

// File: tb/tb_bp_me_wormhole_link_arbiter.sv
// tb/tb_bp_me_wormhole_link_arbiter.sv - directed vector bench for the wormhole link arbiter
module tb_bp_me_wormhole_link_arbiter;

    localparam int N = 2;
    localparam int W = 64;

    logic           clk;
    logic           reset_n;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_v;
    logic           link_rdy;

    logic [N-1:0]   rdy_o, grant_o, rdy2, grant2;
    logic [W-1:0]   data_o, data2;
    logic           v_o, hdr_o, last_o, v2, hdr2, last2;

    bp_me_wormhole_link_arbiter #(.num_req_p(N), .flit_width_p(W), .cord_width_p(4),
                                  .len_width_p(4), .hdr_len_p(1)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_data_i(req_data), .req_v_i(req_v),
        .req_ready_and_o(rdy_o), .link_data_o(data_o), .link_v_o(v_o),
        .link_ready_and_i(link_rdy), .grant_o(grant_o), .is_hdr_o(hdr_o), .last_o(last_o)
    );

    bp_me_wormhole_link_arbiter #(.num_req_p(N), .flit_width_p(W), .cord_width_p(4),
                                  .len_width_p(4), .hdr_len_p(2)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .req_data_i(req_data), .req_v_i(req_v),
        .req_ready_and_o(rdy2), .link_data_o(data2), .link_v_o(v2),
        .link_ready_and_i(link_rdy), .grant_o(grant2), .is_hdr_o(hdr2), .last_o(last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [63:0] d0, d1;
        logic        rdy;
        logic        ev;
        logic [1:0]  eg;
        logic [63:0] ed;
        logic        eh, el;
        logic [1:0]  er;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic logic [63:0] fl(input logic [3:0] len, input logic [15:0] tag);
        return {tag, 40'h0, len, 4'h0};
    endfunction

    task automatic add(input logic rst, input logic [1:0] v, input logic [63:0] d0, d1,
                       input logic rdy, input logic ev, input logic [1:0] eg,
                       input logic [63:0] ed, input logic eh, el, input logic [1:0] er);
        vec_t t;
        t.rst = rst; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.ev = ev; t.eg = eg; t.ed = ed; t.eh = eh; t.el = el; t.er = er;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] d0, d1, input logic rdy);
        req_v    = v;
        req_data = {d1, d0};
        link_rdy = rdy;
    endtask

    logic [63:0] z;

    initial begin
        z = 64'h0;
        reset_n = 1'b0;
        drive(2'b00, z, z, 1'b1);
        repeat (2) @(posedge clk);

        // Single requester: len 0, 2, 0 back to back
        add(1, 2'b00, z, z, 1,  0, 2'b00, z, 0, 0, 2'b00);
        add(0, 2'b01, fl(0,16'h0A0), z, 1,  1, 2'b01, fl(0,16'h0A0), 1, 1, 2'b01);
        add(0, 2'b01, fl(2,16'h0B0), z, 1,  1, 2'b01, fl(2,16'h0B0), 1, 0, 2'b01);
        add(0, 2'b01, fl(0,16'h0B1), z, 1,  1, 2'b01, fl(0,16'h0B1), 0, 0, 2'b01);
        add(0, 2'b01, fl(0,16'h0B2), z, 1,  1, 2'b01, fl(0,16'h0B2), 0, 1, 2'b01);
        add(0, 2'b01, fl(0,16'h0C0), z, 1,  1, 2'b01, fl(0,16'h0C0), 1, 1, 2'b01);
        // Two requesters, len 3 packets, no interleave
        add(1, 2'b00, z, z, 1,  0, 2'b00, z, 0, 0, 2'b00);
        add(0, 2'b11, fl(3,16'h100), fl(3,16'h200), 1,  1, 2'b01, fl(3,16'h100), 1, 0, 2'b01);
        add(0, 2'b11, fl(0,16'h101), fl(3,16'h200), 1,  1, 2'b01, fl(0,16'h101), 0, 0, 2'b01);
        add(0, 2'b11, fl(0,16'h102), fl(3,16'h200), 1,  1, 2'b01, fl(0,16'h102), 0, 0, 2'b01);
        add(0, 2'b11, fl(0,16'h103), fl(3,16'h200), 1,  1, 2'b01, fl(0,16'h103), 0, 1, 2'b01);
        add(0, 2'b11, fl(3,16'h110), fl(3,16'h200), 1,  1, 2'b10, fl(3,16'h200), 1, 0, 2'b10);
        add(0, 2'b11, fl(3,16'h110), fl(0,16'h201), 1,  1, 2'b10, fl(0,16'h201), 0, 0, 2'b10);
        add(0, 2'b11, fl(3,16'h110), fl(0,16'h202), 1,  1, 2'b10, fl(0,16'h202), 0, 0, 2'b10);
        add(0, 2'b11, fl(3,16'h110), fl(0,16'h203), 1,  1, 2'b10, fl(0,16'h203), 0, 1, 2'b10);
        add(0, 2'b11, fl(3,16'h110), fl(3,16'h210), 1,  1, 2'b01, fl(3,16'h110), 1, 0, 2'b01);
        // req0 bubble mid-packet holds the lock against req1
        add(1, 2'b00, z, z, 1,  0, 2'b00, z, 0, 0, 2'b00);
        add(0, 2'b11, fl(2,16'h300), fl(0,16'h400), 1,  1, 2'b01, fl(2,16'h300), 1, 0, 2'b01);
        for (int i = 0; i < 3; i++)
            add(0, 2'b10, fl(0,16'h301), fl(0,16'h400), 1,  0, 2'b01, fl(0,16'h301), 0, 0, 2'b01);
        add(0, 2'b11, fl(0,16'h301), fl(0,16'h400), 1,  1, 2'b01, fl(0,16'h301), 0, 0, 2'b01);
        add(0, 2'b11, fl(0,16'h302), fl(0,16'h400), 1,  1, 2'b01, fl(0,16'h302), 0, 1, 2'b01);
        add(0, 2'b10, z, fl(0,16'h400), 1,  1, 2'b10, fl(0,16'h400), 1, 1, 2'b10);
        add(0, 2'b00, z, z, 1,  0, 2'b00, z, 0, 0, 2'b00);
        // Link stalled: presented req1 flit must not be swapped for req0
        add(1, 2'b00, z, z, 1,  0, 2'b00, z, 0, 0, 2'b00);
        add(0, 2'b10, z, fl(0,16'h500), 0,  1, 2'b10, fl(0,16'h500), 1, 1, 2'b00);
        add(0, 2'b11, fl(0,16'h600), fl(0,16'h500), 0,  1, 2'b10, fl(0,16'h500), 1, 1, 2'b00);
        add(0, 2'b11, fl(0,16'h600), fl(0,16'h500), 1,  1, 2'b10, fl(0,16'h500), 1, 1, 2'b10);
        add(0, 2'b01, fl(0,16'h600), z, 1,  1, 2'b01, fl(0,16'h600), 1, 1, 2'b01);
        add(0, 2'b00, z, z, 1,  0, 2'b00, z, 0, 0, 2'b00);

        foreach (vq[k]) begin
            @(negedge clk);
            reset_n = ~vq[k].rst;
            drive(vq[k].v, vq[k].d0, vq[k].d1, vq[k].rdy);
            #1;
            chk($sformatf("v%0d.link_v", k),  64'(v_o),     64'(vq[k].ev));
            chk($sformatf("v%0d.grant", k),   64'(grant_o), 64'(vq[k].eg));
            chk($sformatf("v%0d.data", k),    data_o,       vq[k].ed);
            chk($sformatf("v%0d.is_hdr", k),  64'(hdr_o),   64'(vq[k].eh));
            chk($sformatf("v%0d.last", k),    64'(last_o),  64'(vq[k].el));
            chk($sformatf("v%0d.ready", k),   64'(rdy_o),   64'(vq[k].er));
        end

        // Two header flits, len=4 (second instance) alongside one header flit (first instance)
        @(negedge clk); reset_n = 1'b0; drive(2'b00, z, z, 1'b1);
        @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, (k == 0) ? fl(4,16'h700) : fl(0,16'(16'h700 + k)), z, 1'b1);
            #1;
            chk($sformatf("hdr2.f%0d.v", k),    64'(v2),    64'(1));
            chk($sformatf("hdr2.f%0d.hdr", k),  64'(hdr2),  64'(k < 2));
            chk($sformatf("hdr2.f%0d.last", k), 64'(last2), 64'(k == 4));
            chk($sformatf("hdr1.f%0d.hdr", k),  64'(hdr_o), 64'(k == 0));
            @(negedge clk);
        end
        drive(2'b00, z, z, 1'b1);

        // Mid-packet asynchronous reset restores rr_ptr=0 and e_arb
        @(negedge clk);
        drive(2'b01, fl(0,16'h800), z, 1'b1);
        #1 chk("rst.pre_pkt0.grant", 64'(grant_o), 64'(2'b01));
        @(negedge clk);
        drive(2'b10, z, fl(4,16'h900), 1'b1);
        #1 chk("rst.pre_pkt1.grant", 64'(grant_o), 64'(2'b10));
        @(negedge clk);
        drive(2'b11, fl(0,16'h810), fl(0,16'h901), 1'b1);
        #1 chk("rst.pre_lock.grant", 64'(grant_o), 64'(2'b10));
        @(negedge clk);
        drive(2'b11, fl(0,16'h810), fl(0,16'h902), 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst.async.link_v", 64'(v_o),     64'(0));
        chk("rst.async.grant",  64'(grant_o), 64'(0));
        chk("rst.async.ready",  64'(rdy_o),   64'(0));
        chk("rst.async.is_hdr", 64'(hdr_o),   64'(0));
        chk("rst.async.last",   64'(last_o),  64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst.after.grant",  64'(grant_o), 64'(2'b01));
        chk("rst.after.data",   data_o,       fl(0,16'h810));
        chk("rst.after.is_hdr", 64'(hdr_o),   64'(1));
        chk("rst.after.last",   64'(last_o),  64'(1));
        @(negedge clk);
        drive(2'b00, z, z, 1'b1);
        #1 chk("rst.idle.link_v", 64'(v_o), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
